// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_pkg
// Purpose  : Shared state encoding, default parameters and a counter-width
//            helper for the SRAM controller and its wait counter.
// Revision : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

   // Controller phases: wait for a request, hold the SRAM bus, release pipeline
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   localparam int unsigned DEF_BASE_ADDR   = 1024;
   localparam int unsigned DEF_WAIT_CYCLES = 5;
   localparam int unsigned DEF_ADDR_W      = 17;
   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_MEM_WORDS   = 512;

   // Bits needed to count 0 .. n-1 (at least one bit)
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage : sram_ctrl_pkg
`default_nettype wire

// File: rtl/sram_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : sram_wait_counter
// Purpose  : Counts clocks spent holding an SRAM access and flags the last
//            one (count == WAIT_CYCLES-1). Clear has priority over enable.
// Revision : 1.0 - initial release
// ============================================================================
module sram_wait_counter
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter int unsigned CNT_W       = cnt_width(DEF_WAIT_CYCLES)
) (
   input  logic clk,
   input  logic rst,        // asynchronous, active-low
   input  logic clear_i,
   input  logic enable_i,
   output logic tc_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear wins, otherwise advance while enabled
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = (count_q == CNT_W'(WAIT_CYCLES - 1));

endmodule : sram_wait_counter
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_controller
// Purpose  : Bridges the MEM stage to an external asynchronous 32-bit SRAM.
//            Byte addresses are rebased to BASE_ADDR and converted to word
//            addresses; each access holds the bus for WAIT_CYCLES clocks and
//            ready is dropped to freeze the pipeline meanwhile.
//            Optional macro SRAM_CTRL_RANGE_CHECK_EN: requests outside the
//            populated window skip the SRAM and pulse addr_err.
// Revision : 1.0 - initial release
// ============================================================================
module sram_controller
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
   parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned MEM_WORDS   = DEF_MEM_WORDS
) (
   input  logic              clk,
   input  logic              rst,        // asynchronous, active-low
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [31:0]       address,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] read_data,
   output logic              ready,
   output logic              addr_err,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic              SRAM_WE_N,
   inout  wire  [DATA_W-1:0] SRAM_DQ
);

   localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                op_wr_q, op_wr_d;
   logic                we_n_q, we_n_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic                w_req;
   logic [31:0]         w_offset;
   logic [ADDR_W-1:0]   w_word;
   logic                w_bad;
   logic                w_tc;
   logic                w_unused;

   assign w_req    = wr_en | rd_en;
   assign w_offset = address - 32'(BASE_ADDR);
   assign w_word   = w_offset[ADDR_W+1:2];

`ifdef SRAM_CTRL_RANGE_CHECK_EN
   assign w_bad = (address < 32'(BASE_ADDR)) || ((w_offset >> 2) >= 32'(MEM_WORDS));
`else
   assign w_bad = 1'b0;
`endif

   // Byte-lane bits and bits above the word range never reach the SRAM
   assign w_unused = ^{w_offset[1:0], w_offset[31:ADDR_W+2], 32'(MEM_WORDS)};

   sram_wait_counter #(
      .WAIT_CYCLES (WAIT_CYCLES),
      .CNT_W       (CNT_W)
   ) u_wait_cnt (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (state_q == ST_IDLE),
      .enable_i (state_q == ST_ACCESS),
      .tc_o     (w_tc)
   );

   // Next-state logic: latch a request in IDLE, hold the bus through ACCESS
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      op_wr_d = op_wr_q;
      we_n_d  = we_n_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_req) begin
               if (w_bad) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  addr_d  = w_word;
                  wdata_d = wr_data;
                  op_wr_d = wr_en;        // write wins when both are set
                  we_n_d  = ~wr_en;
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_ACCESS: begin
            if (w_tc) begin
               if (!op_wr_q) begin
                  rdata_d = SRAM_DQ;
               end
               we_n_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // A request still asserted here belongs to the access just finished
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and bus registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         op_wr_q <= 1'b0;
         we_n_q  <= 1'b1;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         op_wr_q <= op_wr_d;
         we_n_q  <= we_n_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Ready falls in the same cycle a request shows up so the pipeline freezes
   assign ready     = ((state_q == ST_IDLE) && !w_req) || (state_q == ST_DONE);
   assign read_data = rdata_q;
   assign addr_err  = err_q;
   assign SRAM_ADDR = addr_q;
   assign SRAM_WE_N = we_n_q;

   // Drive DQ only while writing; released in DONE so the SRAM may drive it
   assign SRAM_DQ = ((state_q == ST_ACCESS) && op_wr_q) ? wdata_q : {DATA_W{1'bz}};

endmodule : sram_controller
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_controller
// Purpose  : Self-checking bench for sram_controller with an SRAM model on
//            the DQ bus, a reference memory and a completion scoreboard.
//            Honours SRAM_CTRL_RANGE_CHECK_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

   localparam int unsigned BASE      = 1024;
   localparam int unsigned WAIT      = 5;
   localparam int unsigned ADDR_W    = 17;
   localparam int unsigned MEM_WORDS = 512;
   localparam int unsigned SRAM_SIZE = 1 << ADDR_W;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] read_data;
   logic        ready;
   logic        addr_err;
   logic [16:0] SRAM_ADDR;
   logic        SRAM_WE_N;
   wire  [31:0] sram_dq;

   always #5 clk = ~clk;

   sram_controller dut (
      .clk       (clk),
      .rst       (rst_n),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .address   (address),
      .wr_data   (wr_data),
      .read_data (read_data),
      .ready     (ready),
      .addr_err  (addr_err),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_WE_N (SRAM_WE_N),
      .SRAM_DQ   (sram_dq)
   );

   // ---------------- SRAM model: async read, writes while WE_N low --------
   logic [31:0] sram_mem [0:SRAM_SIZE-1];

   function automatic logic [31:0] init_pat(input int unsigned w);
      return (w * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
   endfunction

   initial begin
      for (int i = 0; i < SRAM_SIZE; i++) sram_mem[i] = init_pat(i);
   end

   assign sram_dq = SRAM_WE_N ? sram_mem[SRAM_ADDR] : 32'hzzzz_zzzz;

   always @(posedge clk) begin
      if (!SRAM_WE_N) sram_mem[SRAM_ADDR] <= sram_dq;
   end

   // ---------------- reference model and scoreboard ------------------------
   typedef struct {
      logic        is_wr;
      logic        err;
      logic [31:0] word;
      logic [31:0] data;
      logic [31:0] rd;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] last_rd = '0;
   int          n_vec = 0;
   int          n_mis = 0;
   logic        mon_en = 1'b0;

   function automatic logic [31:0] ref_read(input int unsigned w);
      return ref_mem.exists(w) ? ref_mem[w] : init_pat(w);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Issue one MEM-stage request and hold it until ready returns
   task automatic do_access(input logic w, input logic r, input logic [31:0] a,
                            input logic [31:0] d);
      exp_t        e;
      logic [31:0] off;
      logic        got;
      off     = a - BASE;
      e.is_wr = w;
      e.word  = (off / 4) % SRAM_SIZE;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
      e.err   = (a < BASE) || ((off / 4) >= MEM_WORDS);
`else
      e.err   = 1'b0;
`endif
      e.data  = d;
      if (!e.err) begin
         if (w) ref_mem[e.word] = d;
         else   last_rd = ref_read(e.word);
      end
      e.rd = last_rd;
      sb.push_back(e);

      @(posedge clk); #1;
      wr_en = w; rd_en = r; address = a; wr_data = d;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (ready) got = 1'b1;
      end
      if (!got) begin
         n_vec++; n_mis++;
         $display("FAIL ready_timeout: ready stayed 0 for addr %h", a);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         wr_en = 1'b0; rd_en = 1'b0;
      end
   endtask

   // ---------------- monitor: checks every completed access ----------------
   int   low_cnt = 0;
   int   we_cnt = 0;
   logic prev_ready = 1'b1;
   exp_t me;

   always @(negedge clk) begin
      if (!mon_en) begin
         low_cnt = 0; we_cnt = 0; prev_ready = 1'b1;
      end else begin
         if (!SRAM_WE_N) we_cnt++;
         if (!ready) begin
            low_cnt++;
         end else if (!prev_ready) begin
            if (sb.size() == 0) begin
               n_vec++; n_mis++;
               $display("FAIL unexpected_done: completion with empty scoreboard");
            end else begin
               me = sb.pop_front();
               chk("latency", low_cnt, me.err ? 1 : WAIT + 1);
               chk("we_n_low_cycles", we_cnt, (me.is_wr && !me.err) ? WAIT : 0);
               chk("read_data", read_data, me.rd);
               chk("addr_err", {31'd0, addr_err}, {31'd0, me.err});
               if (!me.err) chk("sram_addr", {15'd0, SRAM_ADDR}, me.word);
               if (me.is_wr && !me.err) chk("sram_word", sram_mem[me.word[16:0]], me.data);
            end
            low_cnt = 0; we_cnt = 0;
         end
         prev_ready = ready;
      end
   end

   // ---------------- stimulus ----------------------------------------------
   initial begin
      logic        w, r;
      logic [31:0] a;
      int          sel;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
      chk("rst_sram_addr", {15'd0, SRAM_ADDR}, 32'd0);
      chk("rst_read_data", read_data, 32'd0);
      chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd1);

      // Reset asserted in the middle of a write
      @(posedge clk); #1;
      wr_en = 1'b1; address = BASE + 1200; wr_data = 32'h1234_5678;
      repeat (3) @(posedge clk);
      #1 chk("midwrite_we_n", {31'd0, SRAM_WE_N}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
      chk("midrst_sram_addr", {15'd0, SRAM_ADDR}, 32'd0);
      chk("midrst_read_data", read_data, 32'd0);
      chk("midrst_dq_released", sram_dq, sram_mem[0]);
      wr_en = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_ready", {31'd0, ready}, 32'd1);
      mon_en = 1'b1;

      // Directed accesses
      do_access(1'b1, 1'b0, BASE, 32'hDEAD_BEEF);
      do_access(1'b0, 1'b1, BASE, 32'h0);
      idle(3);
      @(negedge clk);
      chk("read_data_held", read_data, 32'hDEAD_BEEF);
      do_access(1'b1, 1'b0, BASE + 4, 32'hA5A5_0001);
      do_access(1'b1, 1'b0, BASE + 8, 32'hA5A5_0002);
      do_access(1'b0, 1'b1, BASE + 4, 32'h0);
      do_access(1'b0, 1'b1, BASE + 8, 32'h0);
      do_access(1'b0, 1'b1, BASE + 6, 32'h0);
      do_access(1'b1, 1'b1, BASE + 12, 32'd5);
      do_access(1'b0, 1'b1, BASE + 12, 32'h0);
      do_access(1'b1, 1'b0, BASE + 1200, 32'h0BAD_F00D);
      do_access(1'b1, 1'b0, BASE + 4 * MEM_WORDS, 32'h7777_0000);
      do_access(1'b0, 1'b1, BASE + 4 * MEM_WORDS, 32'h0);
      do_access(1'b0, 1'b1, 32'd1000, 32'h0);
      do_access(1'b1, 1'b0, 32'd0, 32'hC0DE_0000);
      do_access(1'b0, 1'b1, 32'd0, 32'h0);
      idle(2);

      // Randomised traffic
      for (int k = 0; k < 200; k++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)      a = $urandom;
         else if (sel == 1) a = $urandom_range(0, BASE - 1);
         else               a = BASE + 4 * $urandom_range(0, 63) + $urandom_range(0, 3);
         sel = $urandom_range(0, 9);
         w = (sel < 4) || (sel == 9);
         r = (sel >= 4);
         do_access(w, r, a, $urandom);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end
      idle(4);
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule : tb_sram_controller
`default_nettype wire
